// File: rtl/vx_dcache_responder_pkg.sv
// Shared constants, FSM state type and byte-merge helper for the dcache responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vx_dcache_responder_pkg;

  localparam int NUM_REQS   = 4;
  localparam int WORD_SIZE  = 4;
  localparam int ADDR_WIDTH = 30;
  localparam int TAG_WIDTH  = 8;
  localparam int MEM_WORDS  = 1024;

  localparam int DATA_WIDTH = 8 * WORD_SIZE;
  localparam int IDX_W      = $clog2(MEM_WORDS);
  localparam int LANE_W     = $clog2(NUM_REQS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Replace only the bytes selected by be; be==0 returns old_w untouched.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [WORD_SIZE-1:0]  be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int b = 0; b < WORD_SIZE; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/vx_dcache_responder_if.sv
// Multi-lane dcache request bus plus single response channel.
// Latency: n/a (wires only).
// Backpressure: req_ready gates the whole batch, rsp_ready holds the response.
interface vx_dcache_responder_if;
  import vx_dcache_responder_pkg::*;

  logic [NUM_REQS-1:0]                  req_valid;
  logic [NUM_REQS-1:0]                  req_rw;
  logic [NUM_REQS-1:0][WORD_SIZE-1:0]   req_byteen;
  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]  req_addr;
  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]  req_data;
  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]   req_tag;
  logic [NUM_REQS-1:0]                  req_ready;

  logic                                 rsp_valid;
  logic [NUM_REQS-1:0]                  rsp_tmask;
  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]  rsp_data;
  logic [TAG_WIDTH-1:0]                 rsp_tag;
  logic                                 rsp_ready;

  // Requester side (execute stage).
  modport master (
    output req_valid, req_rw, req_byteen, req_addr, req_data, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_tmask, rsp_data, rsp_tag
  );

  // Responder side (memory).
  modport slave (
    input  req_valid, req_rw, req_byteen, req_addr, req_data, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_tmask, rsp_data, rsp_tag
  );

endinterface

// File: rtl/vx_drsp_lane_sel.sv
// Lowest-set-bit picker over a lane mask: index, any-set flag, and "only one left" flag.
// Latency: combinational.
// Backpressure: none.
module vx_drsp_lane_sel
  import vx_dcache_responder_pkg::*;
(
  input  logic [NUM_REQS-1:0] mask,
  output logic [LANE_W-1:0]   idx,
  output logic                vld,
  output logic                is_last
);

  // Scan from the top so the lowest set bit is the final assignment.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = LANE_W'(i);
        vld = 1'b1;
      end
    end
    is_last = vld && ((mask & (mask - NUM_REQS'(1))) == '0);
  end

endmodule

// File: rtl/vx_dcache_responder.sv
// Serial multi-lane scratchpad responder: one batch in, lanes serviced lowest-first, one response out.
// Latency: k valid lanes -> rsp_valid (or req_ready for all-write batches) k+1 cycles after accept.
// Backpressure: req_ready low from accept until idle again; response held stable until rsp_ready.
// Optional feature macro: DRSP_PERF_EN adds perf_reads/perf_writes/perf_stalls counters.
module vx_dcache_responder
  import vx_dcache_responder_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  vx_dcache_responder_if.slave   bus
`ifdef DRSP_PERF_EN
  ,
  output logic [31:0]            perf_reads,
  output logic [31:0]            perf_writes,
  output logic [31:0]            perf_stalls
`endif
);

  state_e                               state_q, state_d;
  logic [NUM_REQS-1:0]                  pend_q, pend_d;
  logic [NUM_REQS-1:0]                  rw_q, rw_d;
  logic [NUM_REQS-1:0][WORD_SIZE-1:0]   be_q, be_d;
  logic [NUM_REQS-1:0][IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]  wdat_q, wdat_d;
  logic                                 wrap_q, wrap_d;
  logic                                 rd_seen_q, rd_seen_d;
  logic                                 req_ready_q, req_ready_d;
  logic                                 rsp_valid_q, rsp_valid_d;
  logic [NUM_REQS-1:0]                  tmask_q, tmask_d;
  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [TAG_WIDTH-1:0]                 tag_q, tag_d;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [LANE_W-1:0]     sel_idx, first_idx;
  logic                  sel_vld, sel_last, first_vld;
  logic                  unused_first_last;
  logic                  unused_addr_hi;
  logic [DATA_WIDTH-1:0] mem_rd, wr_word;
  logic                  mem_wr_en;

  // Next lane to service from the pending mask.
  vx_drsp_lane_sel u_sel (
    .mask    (pend_q),
    .idx     (sel_idx),
    .vld     (sel_vld),
    .is_last (sel_last)
  );

  // Lowest valid lane of the incoming batch supplies the response tag.
  vx_drsp_lane_sel u_first (
    .mask    (bus.req_valid),
    .idx     (first_idx),
    .vld     (first_vld),
    .is_last (unused_first_last)
  );

  // Address bits above the storage index deliberately alias.
  always_comb begin
    unused_addr_hi = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      unused_addr_hi = unused_addr_hi ^ (^bus.req_addr[i][ADDR_WIDTH-1:IDX_W]);
    end
  end

  assign mem_rd    = mem[idx_q[sel_idx]];
  assign wr_word   = merge_bytes(mem_rd, wdat_q[sel_idx], be_q[sel_idx]);
  assign mem_wr_en = (state_q == ACCESS) && !wrap_q && sel_vld && rw_q[sel_idx];

  // Storage: one read-modify-write per cycle, never reset.
  always_ff @(posedge clk) begin
    if (mem_wr_en) mem[idx_q[sel_idx]] <= wr_word;
  end

  // Next-state and registered-output computation for the batch FSM.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    rw_d        = rw_q;
    be_d        = be_q;
    idx_d       = idx_q;
    wdat_d      = wdat_q;
    wrap_d      = wrap_q;
    rd_seen_d   = rd_seen_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    tmask_d     = tmask_q;
    rdata_d     = rdata_q;
    tag_d       = tag_q;
    case (state_q)
      IDLE: begin
        if (first_vld) begin
          pend_d    = bus.req_valid;
          rw_d      = bus.req_rw;
          be_d      = bus.req_byteen;
          wdat_d    = bus.req_data;
          for (int i = 0; i < NUM_REQS; i++) idx_d[i] = bus.req_addr[i][IDX_W-1:0];
          tag_d       = bus.req_tag[first_idx];
          tmask_d     = '0;
          rdata_d     = '0;
          wrap_d      = 1'b0;
          rd_seen_d   = 1'b0;
          req_ready_d = 1'b0;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (wrap_q) begin
          // Closing cycle after the last lane: respond only if something was read.
          wrap_d      = 1'b0;
          rsp_valid_d = rd_seen_q;
          req_ready_d = !rd_seen_q;
          state_d     = rd_seen_q ? RESP : IDLE;
        end else if (sel_vld) begin
          pend_d[sel_idx] = 1'b0;
          wrap_d          = sel_last;
          if (!rw_q[sel_idx]) begin
            rdata_d[sel_idx] = mem_rd;
            tmask_d[sel_idx] = 1'b1;
            rd_seen_d        = 1'b1;
          end
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and captured-batch registers; storage stays outside the reset domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      rw_q        <= '0;
      be_q        <= '0;
      idx_q       <= '0;
      wdat_q      <= '0;
      wrap_q      <= 1'b0;
      rd_seen_q   <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      tmask_q     <= '0;
      rdata_q     <= '0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      rw_q        <= rw_d;
      be_q        <= be_d;
      idx_q       <= idx_d;
      wdat_q      <= wdat_d;
      wrap_q      <= wrap_d;
      rd_seen_q   <= rd_seen_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      tmask_q     <= tmask_d;
      rdata_q     <= rdata_d;
      tag_q       <= tag_d;
    end
  end

  assign bus.req_ready = {NUM_REQS{req_ready_q}};
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_tmask = tmask_q;
  assign bus.rsp_data  = rdata_q;
  assign bus.rsp_tag   = tag_q;

`ifdef DRSP_PERF_EN
  logic [31:0] perf_reads_q, perf_reads_d;
  logic [31:0] perf_writes_q, perf_writes_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;
  logic        svc;

  // Lane-level read/write counts and stalled-request cycles, free-running modulo 2^32.
  always_comb begin
    svc           = (state_q == ACCESS) && !wrap_q && sel_vld;
    perf_reads_d  = perf_reads_q  + 32'(svc && !rw_q[sel_idx]);
    perf_writes_d = perf_writes_q + 32'(svc && rw_q[sel_idx]);
    perf_stalls_d = perf_stalls_q + 32'((|bus.req_valid) && !req_ready_q);
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_reads_q  <= '0;
      perf_writes_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_reads_q  <= perf_reads_d;
      perf_writes_q <= perf_writes_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_reads  = perf_reads_q;
  assign perf_writes = perf_writes_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_vx_dcache_responder.sv
// Directed bench for vx_dcache_responder with a reference memory and response scoreboard.
module tb_vx_dcache_responder;
  import vx_dcache_responder_pkg::*;

  typedef struct {
    logic [NUM_REQS-1:0]            tmask;
    logic [NUM_REQS*DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]           tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vx_dcache_responder_if bus();

`ifdef DRSP_PERF_EN
  logic [31:0] perf_reads, perf_writes, perf_stalls;
`endif

  vx_dcache_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DRSP_PERF_EN
    ,
    .perf_reads  (perf_reads),
    .perf_writes (perf_writes),
    .perf_stalls (perf_stalls)
`endif
  );

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic [DATA_WIDTH-1:0] tb_mem [MEM_WORDS];
  int   tb_reads = 0;
  int   tb_writes = 0;

  logic [NUM_REQS-1:0]                  b_valid, b_rw;
  logic [NUM_REQS-1:0][WORD_SIZE-1:0]   b_be;
  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]  b_addr;
  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]  b_data;
  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]   b_tag;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_batch();
    b_valid = '0; b_rw = '0; b_be = '0; b_addr = '0; b_data = '0; b_tag = '0;
  endtask

  task automatic set_lane(input int i, input logic rw, input logic [3:0] be,
                          input logic [29:0] addr, input logic [31:0] data, input logic [7:0] tag);
    b_valid[i] = 1'b1; b_rw[i] = rw; b_be[i] = be;
    b_addr[i] = addr; b_data[i] = data; b_tag[i] = tag;
  endtask

  // Drive the batch, update the reference memory lane by lane, queue the expected response.
  task automatic send_batch(output int k);
    exp_t e;
    logic [IDX_W-1:0] ix;
    int n;
    bus.req_valid  = b_valid;
    bus.req_rw     = b_rw;
    bus.req_byteen = b_be;
    bus.req_addr   = b_addr;
    bus.req_data   = b_data;
    bus.req_tag    = b_tag;
    e.tmask = '0; e.data = '0; e.tag = '0; k = 0;
    for (int i = NUM_REQS - 1; i >= 0; i--) if (b_valid[i]) e.tag = b_tag[i];
    for (int i = 0; i < NUM_REQS; i++) begin
      if (b_valid[i]) begin
        k++;
        ix = b_addr[i][IDX_W-1:0];
        if (b_rw[i]) begin
          for (int b = 0; b < WORD_SIZE; b++)
            if (b_be[i][b]) tb_mem[ix][8*b +: 8] = b_data[i][8*b +: 8];
          tb_writes++;
        end else begin
          e.data[DATA_WIDTH*i +: DATA_WIDTH] = tb_mem[ix];
          e.tmask[i] = 1'b1;
          tb_reads++;
        end
      end
    end
    if (e.tmask != '0) exp_q.push_back(e);
    n = 0;
    while (bus.req_ready !== 4'hF && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("accept_ready", bus.req_ready, 4'hF);
    @(posedge clk); #1;
    bus.req_valid = '0;
    check("busy_after_accept", bus.req_ready, 4'h0);
  endtask

  // Wait for rsp_valid, check latency from the accept edge, compare with the scoreboard head.
  task automatic wait_rsp(input int exp_lat, input string tag);
    exp_t e;
    int n;
    logic found;
    n = 0; found = 1'b0;
    while (!found && n < 40) begin
      @(posedge clk); #1; n++;
      if (bus.rsp_valid === 1'b1) found = 1'b1;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_pending"}, exp_q.size() != 0, 1'b1);
    if (found && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_tmask"}, bus.rsp_tmask, e.tmask);
      check({tag, "_data"},  bus.rsp_data,  e.data);
      check({tag, "_tag"},   bus.rsp_tag,   e.tag);
    end
  endtask

  task automatic handshake(input string tag);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check({tag, "_rsp_dropped"}, bus.rsp_valid, 1'b0);
    check({tag, "_ready_back"},  bus.req_ready, 4'hF);
  endtask

  // For batches without reads: count cycles until req_ready returns, no response allowed.
  task automatic wait_idle(input int exp_cyc, input string tag);
    int n;
    logic seen;
    n = 0; seen = 1'b0;
    while (n < 40) begin
      @(posedge clk); #1; n++;
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
      if (bus.req_ready === 4'hF) break;
    end
    check({tag, "_ready_cycles"}, n, exp_cyc);
    check({tag, "_no_rsp"}, seen, 1'b0);
  endtask

  initial begin
    int k;
    logic [159:0] snap;
    logic seen;
    bus.req_valid = '0; bus.req_rw = '0; bus.req_byteen = '0;
    bus.req_addr = '0; bus.req_data = '0; bus.req_tag = '0;
    bus.rsp_ready = 1'b0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 4'hF);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_tmask", bus.rsp_tmask, 4'h0);
    check("rst_rsp_data",  bus.rsp_data,  128'h0);
    check("rst_rsp_tag",   bus.rsp_tag,   8'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Write then four-lane read of the same word.
    clear_batch(); set_lane(0, 1'b1, 4'hF, 30'h10, 32'hDEADBEEF, 8'h01);
    send_batch(k); wait_idle(k + 1, "wr10");
    clear_batch();
    for (int i = 0; i < NUM_REQS; i++) set_lane(i, 1'b0, 4'h0, 30'h10, 32'h0, 8'h10 + 8'(i));
    send_batch(k); wait_rsp(5, "rd4"); handshake("rd4");

    // Partial-byte write merged into a prior value, read later in the same batch.
    clear_batch(); set_lane(0, 1'b1, 4'hF, 30'h5, 32'hAABBCCDD, 8'h02);
    send_batch(k); wait_idle(2, "wr5");
    clear_batch();
    set_lane(0, 1'b1, 4'b0011, 30'h5, 32'h11223344, 8'h33);
    set_lane(2, 1'b0, 4'h0,    30'h5, 32'h0,        8'h77);
    send_batch(k); wait_rsp(3, "merge");
    check("merge_tag_const", bus.rsp_tag, 8'h33);
    check("merge_lane2_const", bus.rsp_data[2], 32'hAABB3344);
    handshake("merge");

    // All-write batch of three lanes, including a zero-byteen write to the same word.
    clear_batch();
    set_lane(0, 1'b1, 4'hF, 30'h20, 32'h01020304, 8'h04);
    set_lane(1, 1'b1, 4'hF, 30'h21, 32'h05060708, 8'h05);
    set_lane(3, 1'b1, 4'h0, 30'h21, 32'hFFFFFFFF, 8'h06);
    send_batch(k); wait_idle(4, "wr3");

    // Held response: stable outputs, no accept of a waiting batch until the handshake.
    clear_batch();
    set_lane(0, 1'b0, 4'h0, 30'h20, 32'h0, 8'h41);
    set_lane(1, 1'b0, 4'h0, 30'h21, 32'h0, 8'h42);
    send_batch(k); wait_rsp(3, "hold");
    snap = {bus.rsp_valid, bus.req_ready, bus.rsp_tmask, bus.rsp_tag, bus.rsp_data};
    clear_batch(); set_lane(2, 1'b0, 4'h0, 30'h10, 32'h0, 8'h55);
    bus.req_valid = b_valid; bus.req_addr = b_addr; bus.req_tag = b_tag;
    bus.req_rw = b_rw; bus.req_byteen = b_be; bus.req_data = b_data;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("hold_stable",
            {bus.rsp_valid, bus.req_ready, bus.rsp_tmask, bus.rsp_tag, bus.rsp_data}, snap);
    end
    handshake("hold");
    send_batch(k); wait_rsp(2, "after_hold"); handshake("after_hold");

    // Aliased address, duplicate writes (highest lane wins), read after write.
    clear_batch();
    set_lane(0, 1'b1, 4'hF, 30'h005, 32'h12345678, 8'h60);
    set_lane(1, 1'b1, 4'hF, 30'h005, 32'hCAFEF00D, 8'h61);
    set_lane(3, 1'b0, 4'h0, 30'h405, 32'h0,        8'h63);
    send_batch(k); wait_rsp(4, "alias");
    check("alias_lane3_const", bus.rsp_data[3], 32'hCAFEF00D);
    handshake("alias");
`ifdef DRSP_PERF_EN
    check("perf_reads",  perf_reads,  tb_reads);
    check("perf_writes", perf_writes, tb_writes);
`endif

    // Reset while the response is pending: dropped immediately and never reappears.
    clear_batch(); set_lane(3, 1'b0, 4'h0, 30'h10, 32'h0, 8'h99);
    send_batch(k); wait_rsp(2, "pre_rst");
    #2 reset = 1'b1;
    #1;
    check("rst_mid_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_mid_req_ready", bus.req_ready, 4'hF);
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
    end
    check("rst_no_late_rsp", seen, 1'b0);

    // Storage survives reset.
    clear_batch(); set_lane(0, 1'b0, 4'h0, 30'h10, 32'h0, 8'hA0);
    send_batch(k); wait_rsp(2, "post_rst"); handshake("post_rst");

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
